// File: rtl/omsp_dma_master.sv
// Word block-copy bus initiator for the openMSP430 DMA slave port.
// Optional: define OMSP_DMA_WKUP_EN to drive dma_wkup from a registered copy of busy.
module omsp_dma_master #(
    parameter int LEN_W = 16,
    parameter int AW    = 15
) (
    input  logic             mclk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             abort,
    input  logic [AW-1:0]    cfg_src,
    input  logic [AW-1:0]    cfg_dst,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic             cfg_src_inc,
    input  logic             cfg_dst_inc,
    input  logic             cfg_prio,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [LEN_W-1:0] xfer_cnt,
    output logic             dma_en,
    output logic [AW-1:0]    dma_addr,
    output logic [1:0]       dma_we,
    output logic [15:0]      dma_din,
    output logic             dma_priority,
    input  logic [15:0]      dma_dout,
    input  logic             dma_ready,
    input  logic             dma_resp,
    output logic             dma_wkup
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD      = 3'd1,
        RD_DATA = 3'd2,
        WR      = 3'd3,
        FIN     = 3'd4
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [AW-1:0]    src_q;
    logic [AW-1:0]    dst_q;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] cnt_q;
    logic [LEN_W-1:0] cnt_inc;
    logic [15:0]      data_q;
    logic             src_inc_q;
    logic             dst_inc_q;
    logic             prio_q;
    logic             err_q;

    assign cnt_inc = cnt_q + {{(LEN_W-1){1'b0}}, 1'b1};

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) state_nxt = (cfg_len != '0) ? RD : FIN;
            end
            RD: begin
                // An accepted read always finishes its word; abort only drops a read still waiting.
                if (dma_ready)  state_nxt = RD_DATA;
                else if (abort) state_nxt = FIN;
            end
            RD_DATA: state_nxt = err_q ? FIN : WR;
            WR: begin
                if (dma_ready) begin
                    if (dma_resp || (cnt_inc == len_q) || abort) state_nxt = FIN;
                    else                                         state_nxt = RD;
                end
            end
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge mclk) begin
        if (!reset_n) begin
            state     <= IDLE;
            src_q     <= '0;
            dst_q     <= '0;
            len_q     <= '0;
            cnt_q     <= '0;
            data_q    <= '0;
            src_inc_q <= 1'b0;
            dst_inc_q <= 1'b0;
            prio_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (start) begin
                        src_q     <= cfg_src;
                        dst_q     <= cfg_dst;
                        len_q     <= cfg_len;
                        src_inc_q <= cfg_src_inc;
                        dst_inc_q <= cfg_dst_inc;
                        prio_q    <= cfg_prio;
                        cnt_q     <= '0;
                        err_q     <= 1'b0;
                    end
                end
                RD: begin
                    if (dma_ready && dma_resp) err_q <= 1'b1;
                end
                RD_DATA: data_q <= dma_dout;
                WR: begin
                    if (dma_ready) begin
                        cnt_q <= cnt_inc;
                        // Addresses wrap naturally at the AW-bit boundary.
                        src_q <= src_q + {{(AW-1){1'b0}}, src_inc_q};
                        dst_q <= dst_q + {{(AW-1){1'b0}}, dst_inc_q};
                        if (dma_resp) err_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy         = (state != IDLE);
    assign done         = (state == FIN);
    assign error        = (state == FIN) && err_q;
    assign xfer_cnt     = cnt_q;
    assign dma_en       = (state == RD) || (state == WR);
    assign dma_we       = (state == WR) ? 2'b11 : 2'b00;
    assign dma_addr     = (state == WR) ? dst_q : ((state == RD) ? src_q : '0);
    assign dma_din      = (state == WR) ? data_q : 16'h0000;
    assign dma_priority = busy && prio_q;

`ifdef OMSP_DMA_WKUP_EN
    logic wkup_q;

    always_ff @(posedge mclk) begin
        if (!reset_n) wkup_q <= 1'b0;
        else          wkup_q <= (state_nxt != IDLE);
    end

    assign dma_wkup = wkup_q;
`else
    assign dma_wkup = 1'b0;
`endif

endmodule

// File: tb/tb_omsp_dma_master.sv
// Bench for omsp_dma_master: memory responder, transfer-level model and per-cycle compare.
module tb_omsp_dma_master;

    logic        mclk = 1'b0;
    logic        reset_n;
    logic        start;
    logic        abort;
    logic [14:0] cfg_src;
    logic [14:0] cfg_dst;
    logic [15:0] cfg_len;
    logic        cfg_src_inc;
    logic        cfg_dst_inc;
    logic        cfg_prio;
    logic        busy;
    logic        done;
    logic        error;
    logic [15:0] xfer_cnt;
    logic        dma_en;
    logic [14:0] dma_addr;
    logic [1:0]  dma_we;
    logic [15:0] dma_din;
    logic        dma_priority;
    logic [15:0] dma_dout = 16'h0000;
    logic        dma_ready;
    logic        dma_resp;
    logic        dma_wkup;

    always #5 mclk = ~mclk;

    omsp_dma_master dut (
        .mclk(mclk), .reset_n(reset_n), .start(start), .abort(abort),
        .cfg_src(cfg_src), .cfg_dst(cfg_dst), .cfg_len(cfg_len),
        .cfg_src_inc(cfg_src_inc), .cfg_dst_inc(cfg_dst_inc), .cfg_prio(cfg_prio),
        .busy(busy), .done(done), .error(error), .xfer_cnt(xfer_cnt),
        .dma_en(dma_en), .dma_addr(dma_addr), .dma_we(dma_we), .dma_din(dma_din),
        .dma_priority(dma_priority), .dma_dout(dma_dout), .dma_ready(dma_ready),
        .dma_resp(dma_resp), .dma_wkup(dma_wkup)
    );

    int vectors     = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- memory responder ----------------
    logic [15:0] mem [0:32767] = '{default: 16'h0000};
    int          wait_states = 0;
    int          err_target  = -1;
    int          wcnt    = 0;
    int          rd_cnt  = 0;
    int          acc_cnt = 0;
    int          en_cnt  = 0;
    logic        pk_v = 1'b0;
    logic [14:0] pk_a = '0;
    logic [15:0] pk_d = '0;

    assign dma_ready = dma_en && (wcnt >= wait_states);
    assign dma_resp  = dma_ready && (dma_we == 2'b00) && ((rd_cnt + 1) == err_target);

    always @(posedge mclk) begin
        if (pk_v) mem[pk_a] <= pk_d;
        if (dma_en) en_cnt <= en_cnt + 1;
        if (dma_en && dma_ready) begin
            acc_cnt <= acc_cnt + 1;
            if (dma_we == 2'b00) begin
                rd_cnt   <= rd_cnt + 1;
                dma_dout <= mem[dma_addr];
            end else if (!dma_resp) begin
                mem[dma_addr] <= dma_din;
            end
        end
        if (!dma_en || dma_ready) wcnt <= 0;
        else                      wcnt <= wcnt + 1;
    end

    task automatic poke(input logic [14:0] a, input logic [15:0] d);
        pk_a = a; pk_d = d; pk_v = 1'b1;
        @(posedge mclk); #1;
        pk_v = 1'b0;
    endtask

    // ---------------- transfer-level model ----------------
    typedef struct { logic [14:0] a; logic [1:0] we; logic [15:0] d; } acc_t;
    acc_t exp_q[$];
    int   exp_dur, exp_cnt, armed_gen, gen, rd_base, acc_base, en_base;
    logic exp_err, exp_prio;

    // ---------------- per-cycle compare ----------------
    int          cyc = 0, t0 = 0, idx = 0, done_gen = 0;
    logic        busy_prev = 1'b0, hold = 1'b0;
    logic [14:0] h_addr;
    logic [1:0]  h_we;
    logic [15:0] h_din;

    always @(negedge mclk) begin
        cyc++;
        if (!reset_n) begin
            hold = 1'b0;
            busy_prev = 1'b0;
        end else begin
            chk("wkup_off", dma_wkup, 1'b0);
            chk("priority", dma_priority, busy && exp_prio);
            if (hold) begin
                chk("hold_en", dma_en, 1'b1);
                chk("hold_addr", dma_addr, h_addr);
                chk("hold_we", dma_we, h_we);
                chk("hold_din", dma_din, h_din);
            end
            hold = dma_en && !dma_ready;
            h_addr = dma_addr; h_we = dma_we; h_din = dma_din;
            if (start) idx = 0;
            if (busy && !busy_prev) t0 = cyc;
            busy_prev = busy;
            if (dma_en && dma_ready) begin
                if (idx >= exp_q.size()) begin
                    chk("acc_extra", idx, exp_q.size());
                end else begin
                    chk("acc_addr", dma_addr, exp_q[idx].a);
                    chk("acc_we", dma_we, exp_q[idx].we);
                    if (exp_q[idx].we != 2'b00) chk("acc_din", dma_din, exp_q[idx].d);
                    idx++;
                end
            end
            if (done || error) begin
                if (armed_gen == 0 || armed_gen == done_gen) begin
                    chk("done_unexpected", done, 1'b0);
                end else begin
                    chk("done_with_error", done, 1'b1);
                    chk("done_latency", cyc - t0, exp_dur);
                    chk("done_cnt", xfer_cnt, exp_cnt);
                    chk("done_error", error, exp_err);
                    chk("accesses_left", idx, exp_q.size());
                    done_gen = armed_gen;
                end
            end
        end
    end

    task automatic run(input logic [14:0] src, input logic [14:0] dst, input logic [15:0] len,
                       input logic sinc, input logic dinc, input logic prio,
                       input int w, input int er, input int ab, input bit rst_mid);
        int n, nr, nw, k;
        logic [14:0] ra, wa;
        wait_states = w; exp_prio = prio;
        cfg_src = src; cfg_dst = dst; cfg_len = len;
        cfg_src_inc = sinc; cfg_dst_inc = dinc; cfg_prio = prio;
        rd_base = rd_cnt; acc_base = acc_cnt; en_base = en_cnt;
        err_target = (er > 0) ? rd_base + er : -1;
        n = (ab > 0 && ab < int'(len)) ? ab : int'(len);
        if (er > 0 && er <= n) begin
            nr = er; nw = er - 1; exp_err = 1'b1;
            exp_dur = (er - 1) * (2 * w + 3) + w + 2;
        end else begin
            nr = n; nw = n; exp_err = 1'b0;
            exp_dur = n * (2 * w + 3);
        end
        exp_cnt = nw;
        exp_q.delete();
        for (int i = 0; i < nr; i++) begin
            ra = 15'((int'(src) + (sinc ? i : 0)) % 32768);
            wa = 15'((int'(dst) + (dinc ? i : 0)) % 32768);
            exp_q.push_back('{a: ra, we: 2'b00, d: 16'h0000});
            if (i < nw) exp_q.push_back('{a: wa, we: 2'b11, d: mem[ra]});
        end
        gen++; armed_gen = gen;
        start = 1'b1;
        @(posedge mclk); #1;
        start = 1'b0;
        if (len == 0) chk("len0_done_next_cycle", done, 1'b1);
        if (rst_mid) begin
            for (k = 0; k < 100; k++) begin
                if (dma_we == 2'b11) break;
                @(posedge mclk); #1;
            end
            chk("reached_wr", dma_we, 2'b11);
            reset_n = 1'b0; armed_gen = 0;
            @(posedge mclk); #1;
            chk("rst_en_low", dma_en, 1'b0);
            chk("rst_busy_low", busy, 1'b0);
            chk("rst_no_done", done, 1'b0);
            chk("rst_cnt", xfer_cnt, 16'd0);
            reset_n = 1'b1;
            repeat (6) @(posedge mclk);
            #1;
            chk("rst_idle_busy", busy, 1'b0);
            return;
        end
        if (ab > 0) begin
            for (k = 0; k < 200; k++) begin
                if (rd_cnt >= rd_base + ab) break;
                @(posedge mclk); #1;
            end
            abort = 1'b1;
        end
        for (k = 0; k < 500; k++) begin
            @(negedge mclk);
            if (done) break;
        end
        if (k == 500) chk("done_timeout", done, 1'b1);
        @(posedge mclk); #1;
        abort = 1'b0;
        chk("busy_after_done", busy, 1'b0);
        chk("cnt_holds", xfer_cnt, exp_cnt);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset_n = 1'b0; start = 1'b0; abort = 1'b0;
        cfg_src = '0; cfg_dst = '0; cfg_len = '0;
        cfg_src_inc = 1'b0; cfg_dst_inc = 1'b0; cfg_prio = 1'b0;
        exp_prio = 1'b0; exp_err = 1'b0; exp_dur = 0; exp_cnt = 0;
        armed_gen = 0; gen = 0; rd_base = 0; acc_base = 0; en_base = 0;
        repeat (3) @(posedge mclk);
        #1;
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_error", error, 1'b0);
        chk("rst_xfer_cnt", xfer_cnt, 16'd0);
        chk("rst_dma_en", dma_en, 1'b0);
        chk("rst_dma_we", dma_we, 2'b00);
        chk("rst_dma_addr", dma_addr, 15'd0);
        chk("rst_dma_din", dma_din, 16'd0);
        chk("rst_dma_prio", dma_priority, 1'b0);
        chk("rst_dma_wkup", dma_wkup, 1'b0);
        reset_n = 1'b1;
        abort = 1'b1;
        @(posedge mclk); #1;
        chk("abort_idle_busy", busy, 1'b0);
        abort = 1'b0;

        // zero-wait copy of four words
        for (int i = 0; i < 4; i++) poke(15'h0100 + 15'(i), 16'hA5A0 + 16'(i));
        run(15'h0100, 15'h0200, 16'd4, 1'b1, 1'b1, 1'b0, 0, 0, 0, 1'b0);
        for (int i = 0; i < 4; i++) chk("copy_dst", mem[15'h0200 + 15'(i)], 16'hA5A0 + 16'(i));
        chk("copy_cnt", xfer_cnt, 16'd4);
        chk("copy_dur_lit", exp_dur, 12);

        // three wait states per access
        poke(15'h0300, 16'h1111); poke(15'h0301, 16'h2222);
        run(15'h0300, 15'h0380, 16'd2, 1'b1, 1'b1, 1'b1, 3, 0, 0, 1'b0);
        chk("wait_accesses", acc_cnt - acc_base, 4);
        chk("wait_dst0", mem[15'h0380], 16'h1111);
        chk("wait_dst1", mem[15'h0381], 16'h2222);

        // fixed peripheral source
        poke(15'h0040, 16'h1234);
        run(15'h0040, 15'h0500, 16'd3, 1'b0, 1'b1, 1'b0, 0, 0, 0, 1'b0);
        chk("periph_reads", rd_cnt - rd_base, 3);
        for (int i = 0; i < 3; i++) chk("periph_dst", mem[15'h0500 + 15'(i)], 16'h1234);

        // error response on the second read
        for (int i = 0; i < 5; i++) poke(15'h0600 + 15'(i), 16'h6000 + 16'(i));
        run(15'h0600, 15'h0700, 16'd5, 1'b1, 1'b1, 1'b0, 0, 2, 0, 1'b0);
        chk("err_cnt", xfer_cnt, 16'd1);
        chk("err_dst0", mem[15'h0700], 16'h6000);
        chk("err_no_2nd_write", mem[15'h0701], 16'h0000);

        // abort during the second word
        for (int i = 0; i < 8; i++) poke(15'h0800 + 15'(i), 16'h8000 + 16'(i));
        run(15'h0800, 15'h0900, 16'd8, 1'b1, 1'b1, 1'b0, 0, 0, 2, 1'b0);
        chk("abort_cnt", xfer_cnt, 16'd2);
        chk("abort_reads", rd_cnt - rd_base, 2);
        chk("abort_dst1", mem[15'h0901], 16'h8001);
        chk("abort_no_3rd", mem[15'h0902], 16'h0000);

        // zero length
        run(15'h0100, 15'h0A80, 16'd0, 1'b1, 1'b1, 1'b0, 0, 0, 0, 1'b0);
        chk("len0_no_en", en_cnt - en_base, 0);
        chk("len0_cnt", xfer_cnt, 16'd0);

        // source address wrap
        poke(15'h7FFF, 16'hBEEF); poke(15'h0000, 16'hCAFE);
        run(15'h7FFF, 15'h0A00, 16'd2, 1'b1, 1'b1, 1'b0, 0, 0, 0, 1'b0);
        chk("wrap_dst0", mem[15'h0A00], 16'hBEEF);
        chk("wrap_dst1", mem[15'h0A01], 16'hCAFE);

        // reset while a write is pending
        run(15'h0100, 15'h0B00, 16'd4, 1'b1, 1'b1, 1'b1, 0, 0, 0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
